// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the synchronous instruction ROM
// and presents one instruction word per cycle to the decoder. Supports stall,
// zero-bubble jump redirect, sticky halt on HALT_OPCODE and PC wrap-around.
module fetch_unit #(
  parameter int unsigned       ADDR_W      = 8,
  parameter int unsigned       INSTR_W     = 24,
  parameter logic [ADDR_W-1:0] RESET_PC    = '0,
  parameter logic [7:0]        HALT_OPCODE = 8'hFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               jump_en,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic [ADDR_W-1:0]  rom_addr,
  output logic               rom_en,
  input  logic [INSTR_W-1:0] rom_data,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               halted
);

  typedef enum logic [0:0] {StRun, StHalted} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              pending_q, pending_d;
  logic              halt_hit;
  logic              take_jump;

  // Output decode and ROM request; the ROM holds its data while rom_en is low,
  // so the presented word stays stable across a stall without a local copy.
  always_comb begin
    instr_valid = pending_q && (state_q == StRun);
    instr       = instr_valid ? rom_data : '0;
    // A consumed HALT word ends fetching and overrides any jump in that cycle.
    halt_hit    = instr_valid && !stall && (rom_data[INSTR_W-1 -: 8] == HALT_OPCODE);
    take_jump   = jump_en && instr_valid && !stall && !halt_hit;
    rom_addr    = take_jump ? jump_addr : pc_q;
    rom_en      = rst_n && (state_q == StRun) && !stall;
    pc_out      = fetch_pc_q;
    halted      = (state_q == StHalted);
  end

  // Next-state: every issued fetch records its address and advances the PC
  // (wrapping naturally at 2^ADDR_W); otherwise everything holds.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fetch_pc_d = fetch_pc_q;
    pending_d  = pending_q;
    if (rom_en) begin
      fetch_pc_d = rom_addr;
      pc_d       = rom_addr + ADDR_W'(1);
      pending_d  = 1'b1;
    end
    if (halt_hit) begin
      state_d = StHalted;
    end
  end

  // State registers; reset drops pending so any in-flight ROM data is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      pending_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fetch_pc_q <= fetch_pc_d;
      pending_q  <= pending_d;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: behavioural synchronous ROM, a per-cycle vector table
// of expected outputs, and a queue of issued fetch addresses that must come
// back in order on pc_out.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        jump_en;
  logic [7:0]  jump_addr;
  logic [7:0]  rom_addr;
  logic        rom_en;
  logic [23:0] rom_data;
  logic [23:0] instr;
  logic        instr_valid;
  logic [7:0]  pc_out;
  logic        halted;

  logic [23:0] mem [256];

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] sb [$];

  typedef struct packed {
    logic       st;
    logic       je;
    logic [7:0] ja;
    logic       ev;
    logic [7:0] epc;
    logic       ere;
    logic [7:0] era;
    logic       eh;
  } vec_t;

  vec_t vecs [$];
  int   split;

  fetch_unit #(
    .ADDR_W     (8),
    .INSTR_W    (24),
    .RESET_PC   (8'h00),
    .HALT_OPCODE(8'hFF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stall      (stall),
    .jump_en    (jump_en),
    .jump_addr  (jump_addr),
    .rom_addr   (rom_addr),
    .rom_en     (rom_en),
    .rom_data   (rom_data),
    .instr      (instr),
    .instr_valid(instr_valid),
    .pc_out     (pc_out),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Synchronous ROM: data updates only on an enabled edge, held otherwise.
  initial rom_data = '0;
  always @(posedge clk) begin
    if (rom_en) rom_data <= mem[rom_addr];
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic je, input logic [7:0] ja,
                              input logic ev, input logic [7:0] epc, input logic ere,
                              input logic [7:0] era, input logic eh);
    vec_t v;
    v.st = st; v.je = je; v.ja = ja; v.ev = ev; v.epc = epc;
    v.ere = ere; v.era = era; v.eh = eh;
    return v;
  endfunction

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(negedge clk);
    stall     = v.st;
    jump_en   = v.je;
    jump_addr = v.ja;
    #1;
    chk($sformatf("valid[%0d]", i), 32'(instr_valid), 32'(v.ev));
    chk($sformatf("instr[%0d]", i), 32'(instr), v.ev ? 32'(mem[v.epc]) : 32'h0);
    chk($sformatf("rom_en[%0d]", i), 32'(rom_en), 32'(v.ere));
    chk($sformatf("halted[%0d]", i), 32'(halted), 32'(v.eh));
    if (!v.eh) chk($sformatf("rom_addr[%0d]", i), 32'(rom_addr), 32'(v.era));
    if (v.ev) begin
      chk($sformatf("pc_out[%0d]", i), 32'(pc_out), 32'(v.epc));
      if (sb.size() == 0) begin
        chk($sformatf("sb_empty[%0d]", i), 32'(sb.size()), 32'd1);
      end else begin
        chk($sformatf("sb_pc[%0d]", i), 32'(pc_out), 32'(sb[0]));
        if (!v.st) void'(sb.pop_front());
      end
    end
    if (v.ere) sb.push_back(v.era);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [7:0] a;
      a = 8'(i);
      mem[i] = {1'b0, a[6:0], a, ~a};
    end
    mem[0] = 24'h100105;
    mem[1] = 24'h200203;
    mem[2] = 24'h000000;
    mem[7] = 24'hFF0000;

    //                 st  je  ja     ev  epc    ere va     eh
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h00, 1, 8'h01, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h01, 1, 8'h02, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h02, 0, 8'h03, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h02, 0, 8'h03, 0));
    vecs.push_back(mk(1, 0, 8'h00, 1, 8'h02, 0, 8'h03, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h02, 1, 8'h03, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h03, 1, 8'h04, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h04, 1, 8'h05, 0));
    vecs.push_back(mk(0, 1, 8'h40, 1, 8'h05, 1, 8'h40, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h40, 1, 8'h41, 0));
    vecs.push_back(mk(1, 1, 8'h80, 1, 8'h41, 0, 8'h42, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h41, 1, 8'h42, 0));
    vecs.push_back(mk(0, 1, 8'hFD, 1, 8'h42, 1, 8'hFD, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'hFD, 1, 8'hFE, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'hFE, 1, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'hFF, 1, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'hFF, 1, 8'h00, 1, 8'hFF, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'hFF, 1, 8'h00, 0));
    vecs.push_back(mk(0, 1, 8'h05, 1, 8'h00, 1, 8'h05, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h05, 1, 8'h06, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h06, 1, 8'h07, 0));
    // HALT word with a simultaneous jump: the jump must not steer rom_addr.
    vecs.push_back(mk(0, 1, 8'h30, 1, 8'h07, 1, 8'h08, 0));
    vecs.push_back(mk(0, 1, 8'h30, 0, 8'h00, 0, 8'h00, 1));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 8'h00, 1));
    vecs.push_back(mk(0, 1, 8'h20, 0, 8'h00, 0, 8'h00, 1));
    split = vecs.size();
    // After the reset pulse: stall on the first cycle must not fetch.
    vecs.push_back(mk(1, 0, 8'h00, 0, 8'h00, 0, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 0, 8'h00, 1, 8'h00, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h00, 1, 8'h01, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h01, 1, 8'h02, 0));
    vecs.push_back(mk(0, 0, 8'h00, 1, 8'h02, 1, 8'h03, 0));

    rst_n = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_addr = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_pc_out", 32'(pc_out), 32'd0);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < split; i++) run_vec(i);

    // Asynchronous reset pulse in the middle of the HALTED state.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_halted", 32'(halted), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_instr", 32'(instr), 32'd0);
    chk("midrst_pc_out", 32'(pc_out), 32'd0);
    chk("midrst_rom_en", 32'(rom_en), 32'd0);
    sb.delete();
    @(posedge clk);
    #2 rst_n = 1'b1;
    stall = 1'b1;

    for (int i = split; i < vecs.size(); i++) run_vec(i);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
